regfile_access_ctrl: RTL
========================

Name: regfile_access_ctrl

Overview:
- Initiator-side controller that drives the 32x32 regfile's single write port and dual read ports.
- Accepts writeback requests into a small ordered write buffer and drains them into the regfile one per cycle.
- Serves operand-read requests through a 2-stage valid/ready pipeline. Results are forwarded from pending buffered writes, so reads never return stale data.
- Sits between the execute/writeback stages and regfile.

Parameters:
- DEPTH, 4, write-buffer entries (power of 2, 2..16)
- R0_ZERO, 1, 1: writes to reg 0 are accepted and discarded, and reads of reg 0 return 0

Ports:
- clock  in  1  single clock; all state updates on rising edge
- ctrl_reset  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback request valid
- wb_ready  out  1  writeback request accepted when wb_valid&wb_ready
- wb_reg  in  5  writeback destination register
- wb_data  in  32  writeback data
- drain_en  in  1  1: buffer may write the regfile this cycle
- rd_valid  in  1  operand read request valid
- rd_ready  out  1  read request accepted when rd_valid&rd_ready
- rd_regA, rd_regB  in  5 each  source registers
- op_valid  out  1  operand result valid
- op_ready  in  1  consumer accepts result
- op_a, op_b  out  32 each  operand values
- ctrl_writeEnable  out  1  to regfile
- ctrl_writeReg  out  5  to regfile
- data_writeReg  out  32  to regfile
- ctrl_readRegA, ctrl_readRegB  out  5 each  to regfile (registered)
- data_readRegA, data_readRegB  in  32 each  from regfile (combinational read)
- buf_count  out  clog2(DEPTH)+1  current buffer occupancy

Behaviour:
- Reset, while ctrl_reset=1:
  - buffer emptied; both pipeline stages invalid
  - op_valid=0, op_a=op_b=0, ctrl_readRegA/B=0, buf_count=0, ctrl_writeEnable=0
  - wb_ready=0 and rd_ready=0, forced regardless of state
- Reset mid-operation discards all buffered writes and in-flight reads. Regfile contents are not touched by this block.
- Write buffer:
  - FIFO, in order.
  - wb_ready = !full | (drain this cycle); push and pop allowed in the same cycle when full.
  - With R0_ZERO=1, a write to reg 0 is accepted but not pushed.
- Drain:
  - ctrl_writeEnable = !empty & drain_en, with ctrl_writeReg/data_writeReg driven from the head entry.
  - The regfile captures the write at the same edge that pops the head.
  - Minimum latency: accepted at edge N, written into the regfile at edge N+1 when drain_en=1.
  - drain_en=0 holds all entries; the buffer fills and then wb_ready=0.
- Read pipeline, S1:
  - Accepting a request latches rd_regA/B into ctrl_readRegA/B and sets S1 valid.
  - rd_ready = !S1valid | advance, where advance = S1valid & (!op_valid | op_ready).
- Read pipeline, S2:
  - On advance, op_a/op_b are captured, op_valid=1, and S1 clears unless refilled in the same cycle.
  - op_valid clears on op_ready when there is no advance.
  - op_* hold stable while op_valid&!op_ready.
- Result selection, per port, evaluated combinationally in the advance cycle. Priority, highest first:
  1. reg 0 with R0_ZERO → 0
  2. write accepted this same cycle (wb_valid&wb_ready) to the same reg
  3. youngest matching buffer entry, including the head being drained this cycle
  4. data_readRegA/B
- Ordering guarantee: a result reflects every write accepted at or before its capture edge. Throughput is 1 read/cycle; latency is 2 edges from accept to op_valid.
- Simultaneous events are all legal in one cycle: push, pop, read accept and advance.

Decomposition:
- Shared package (regfile_pkg):
  - REG_W=32, ADDR_W=5, NUM_REGS=32
  - typedef wb_entry_t {addr[4:0], data[31:0]}
- Sub-module regfile_wbuf:
  - DEPTH-entry FIFO plus a youngest-match CAM lookup for two addresses
  - outputs: hit flag and data per lookup port
- The top level holds the read pipeline and the forwarding muxes.

Test Plan:
- Reset, then drain_en=1 and write r5=0xDEADBEEF → ctrl_writeEnable=1 with writeReg=5 the next cycle. A subsequent read of r5/r0 returns op_a=0xDEADBEEF, op_b=0.
- drain_en=0 and writes r3=1, r3=2, r3=3, r3=4 → buf_count=4 and wb_ready=0. A read of r3 returns 4 (youngest match), and the regfile is never written.
- Buffer full, drain_en=1, with a simultaneous new write → wb_ready=1 and buf_count stays 4. Drain order at ctrl_writeReg/data matches acceptance order.
- Read of r7 accepted in the same cycle as write r7=0x55 → result 0x55 (same-cycle forwarding).
- op_ready=0 for 5 cycles with back-to-back reads of r1, r2 → op_a holds the r1 value, rd_ready=0 after S1 fills, and there is no loss or duplication after release.
- ctrl_reset pulsed with 3 buffered writes and a pending op → op_valid=0, buf_count=0, and none of the 3 writes reach the regfile.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and the write-buffer entry type for the regfile access controller.
package regfile_pkg;

  localparam int unsigned REG_W    = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wbuf.sv
// Ordered write buffer with a two-port youngest-match lookup over all live entries.
module regfile_wbuf
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  wb_entry_t                  push_entry_i,
  input  logic                       pop_i,
  output wb_entry_t                  head_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  input  logic [ADDR_W-1:0]          look_a_addr_i,
  input  logic [ADDR_W-1:0]          look_b_addr_i,
  output logic                       hit_a_o,
  output logic [REG_W-1:0]           data_a_o,
  output logic                       hit_b_o,
  output logic [REG_W-1:0]           data_b_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] idx;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Scan oldest to youngest so the last live match wins; the head counts even while popping.
  always_comb begin
    hit_a_o  = 1'b0;
    data_a_o = '0;
    hit_b_o  = 1'b0;
    data_b_o = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (mem_q[idx].addr == look_a_addr_i) begin
          hit_a_o  = 1'b1;
          data_a_o = mem_q[idx].data;
        end
        if (mem_q[idx].addr == look_b_addr_i) begin
          hit_b_o  = 1'b1;
          data_b_o = mem_q[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Regfile initiator: buffered writeback drain plus a 2-stage forwarding operand-read pipeline.
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_reg,
  input  logic [REG_W-1:0]         wb_data,
  input  logic                     drain_en,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [ADDR_W-1:0]        rd_regA,
  input  logic [ADDR_W-1:0]        rd_regB,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [REG_W-1:0]         op_a,
  output logic [REG_W-1:0]         op_b,
  output logic                     ctrl_writeEnable,
  output logic [ADDR_W-1:0]        ctrl_writeReg,
  output logic [REG_W-1:0]         data_writeReg,
  output logic [ADDR_W-1:0]        ctrl_readRegA,
  output logic [ADDR_W-1:0]        ctrl_readRegB,
  input  logic [REG_W-1:0]         data_readRegA,
  input  logic [REG_W-1:0]         data_readRegB,
  output logic [$clog2(DEPTH):0]   buf_count
);

  wb_entry_t         head, push_entry;
  logic              buf_empty, buf_full;
  logic              hit_a, hit_b;
  logic [REG_W-1:0]  hdata_a, hdata_b;
  logic              wb_accept, push, rd_accept, advance;

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d;
  logic              op_valid_q, op_valid_d;
  logic [REG_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;

  assign ctrl_writeEnable = !ctrl_reset && !buf_empty && drain_en;
  assign ctrl_writeReg    = head.addr;
  assign data_writeReg    = head.data;

  assign wb_ready   = !ctrl_reset && (!buf_full || ctrl_writeEnable);
  assign wb_accept  = wb_valid && wb_ready;
  assign push       = wb_accept && !(R0_ZERO && (wb_reg == '0));
  assign push_entry = '{addr: wb_reg, data: wb_data};

  assign advance   = s1_valid_q && (!op_valid_q || op_ready);
  assign rd_ready  = !ctrl_reset && (!s1_valid_q || advance);
  assign rd_accept = rd_valid && rd_ready;

  regfile_wbuf #(.DEPTH(DEPTH)) u_wbuf (
    .clk_i         (clock),
    .rst_i         (ctrl_reset),
    .push_i        (push),
    .push_entry_i  (push_entry),
    .pop_i         (ctrl_writeEnable),
    .head_o        (head),
    .empty_o       (buf_empty),
    .full_o        (buf_full),
    .count_o       (buf_count),
    .look_a_addr_i (ra_q),
    .look_b_addr_i (rb_q),
    .hit_a_o       (hit_a),
    .data_a_o      (hdata_a),
    .hit_b_o       (hit_b),
    .data_b_o      (hdata_b)
  );

  function automatic logic [REG_W-1:0] pick(
    input logic [ADDR_W-1:0] addr,
    input logic              wb_hit,
    input logic              buf_hit,
    input logic [REG_W-1:0]  buf_data,
    input logic [REG_W-1:0]  rf_data
  );
    if (R0_ZERO && (addr == '0)) return '0;
    if (wb_hit)                  return wb_data;
    if (buf_hit)                 return buf_data;
    return rf_data;
  endfunction

  always_comb begin
    s1_valid_d = s1_valid_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    if (rd_accept) begin
      s1_valid_d = 1'b1;
      ra_d       = rd_regA;
      rb_d       = rd_regB;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
    if (advance) begin
      op_valid_d = 1'b1;
      op_a_d     = pick(ra_q, wb_accept && (wb_reg == ra_q), hit_a, hdata_a, data_readRegA);
      op_b_d     = pick(rb_q, wb_accept && (wb_reg == rb_q), hit_b, hdata_b, data_readRegB);
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      s1_valid_q <= 1'b0;
      ra_q       <= '0;
      rb_q       <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
    end
  end

  assign ctrl_readRegA = ra_q;
  assign ctrl_readRegB = rb_q;
  assign op_valid      = op_valid_q;
  assign op_a          = op_a_q;
  assign op_b          = op_b_q;

endmodule
